image_kernel_ctrl: RTL and testbench
====================================

// Module: image_kernel_ctrl
// PURPOSE
// Sequencer for the ImageKernel row-buffer datapath. Parses the dtype-tagged pixel stream and
// generates the row-buffer write address, the rotating write slot, the oldest-row slot for read
// ordering, and pixel/row indices. It also flags beats where a full KERNEL_SIZE x KERNEL_SIZE
// window exists. It sits between the stream input and the kernel row buffers and owns all
// pointer state.
// PARAMETERS
// KERNEL_SIZE  3     rows/cols in kernel window; number of row-buffer slots (>=2)
// MAX_COLS     1280  row-buffer depth; max pixels per row
// ROW_WIDTH    12    width of row counter
// PORTS
// clk          in   1                          system clock, all logic on posedge
// reset        in   1                          synchronous, active-high reset
// enable       in   1                          0: ignore input beats, hold all state, dvo=0
// dvi          in   1                          input beat valid
// dtypei       in   `DTYPE_WIDTH               beat type (dtypes.v)
// dvo          out  1                          registered copy of accepted dvi
// dtypeo       out  `DTYPE_WIDTH               registered copy of dtypei
// we           out  1                          row-buffer write strobe (pixel beats only)
// waddr        out  $clog2(MAX_COLS)           row-buffer column address
// wslot        out  $clog2(KERNEL_SIZE)        slot being written (newest row)
// oldest_slot  out  $clog2(KERNEL_SIZE)        slot holding kernel row 0 = (wslot+1) mod K
// col_idx      out  $clog2(MAX_COLS)           column of current pixel (== waddr)
// row_idx      out  ROW_WIDTH                  row of current pixel within frame
// win_valid    out  1                          window complete: row_idx>=K-1 && col_idx>=K-1
// overflow     out  1                          sticky: row exceeded MAX_COLS pixels
// proto_err    out  1                          sticky: dtype sequence violation
// BEHAVIOUR
// - Reset: every output 0; state IDLE; col=0, row=0, wslot=0, rows_seen=0. Reset beats every input.
// - Latency: one cycle. Outputs for an input beat appear on the next clk edge; all outputs registered.
// - Beat accepted iff enable && dvi. enable=0 holds all state. dvo, we and win_valid are 0 while enable=0.
// - FSM states:
//   - IDLE --FRAME_START--> FRAME.
//   - FRAME --ROW_START--> ROW.
//   - ROW --ROW_END--> FRAME.
//   - FRAME --FRAME_END--> IDLE.
// - FRAME_START in any state: row=0, col=0, wslot=0, rows_seen=0, overflow=0, proto_err=0;
//   go FRAME. A FRAME_START mid-row aborts that row; this is not an error.
// - ROW_START: col=0. If rows_seen>0, wslot advances mod KERNEL_SIZE (K-1 wraps to 0).
// - PIXEL in ROW: we=1, waddr=col, row_idx=row, col increments.
//   - At col==MAX_COLS-1 the write still occurs and col saturates.
//   - Further pixels in that row: we=0, overflow<=1.
// - ROW_END: row increments (saturates at 2^ROW_WIDTH-1); rows_seen increments (saturates at K).
// - Out-of-state beats set proto_err<=1, drive we=0, and leave state unchanged:
//   PIXEL outside ROW, ROW_START in ROW, ROW_END outside ROW, FRAME_END in ROW.
//   dvo/dtypeo still echo the beat.
// - win_valid is asserted only with we=1, when row_idx>=K-1 && col_idx>=K-1.
// - oldest_slot is combinationally derived from the registered wslot; it needs no separate register.
// - Unknown dtype values: pass through on dvo/dtypeo; no state change; no error.
// STRUCTURE
// - dtypes.v (shared) holds `DTYPE_WIDTH and the codes `DTYPE_FRAME_START, `DTYPE_ROW_START,
//   `DTYPE_PIXEL, `DTYPE_ROW_END, `DTYPE_FRAME_END.
// - FSM state encodings are localparams here. They are not shared.
// - Address widths are localparams via $clog2.
// - One sub-module: modk_counter (wrap-at-N incrementer with enable/clear), used for wslot.
// TESTING (K=3, MAX_COLS=8, ROW_WIDTH=4)
// 1 FS, then 4 rows of 5 pixels (RS/PIX*5/RE each), then FE.
//   -> wslot 0,1,2,0 per row; oldest_slot 1,2,0,1.
//   -> win_valid on rows 2-3, cols 2-4 only (6 beats); no errors.
// 2 One row of 10 pixels.
//   -> we on 8 beats, waddr 0..7; beats 9-10 have we=0; overflow=1.
//   -> Next FS clears overflow to 0.
// 3 PIX before any RS; RE in FRAME.
//   -> we=0 on both; proto_err=1; dvo=1, dtypeo echoed one cycle later.
// 4 enable=0 for 3 cycles mid-row with dvi=1.
//   -> dvo=we=0; col, wslot and row unchanged; pixel stream resumes at the held col.
// 5 reset=1 mid-row at col=3, wslot=2.
//   -> next cycle all outputs 0, state IDLE; next PIX has we=0 and proto_err=1.
// 6 FS issued mid-row 2.
//   -> row=0, wslot=0, no proto_err; following row writes slot 0 from waddr 0.

Source files
------------

// File: rtl/image_kernel_ctrl_pkg.sv
// Shared definitions for the ImageKernel row-buffer sequencer: beat-type codes
// and a small slot-arithmetic helper.
package image_kernel_ctrl_pkg;

    localparam int DTYPE_WIDTH = 3;

    typedef logic [DTYPE_WIDTH-1:0] dtype_t;

    // Codes 0, 6 and 7 are unassigned and travel through the block untouched.
    localparam dtype_t DTYPE_FRAME_START = 3'd1;
    localparam dtype_t DTYPE_ROW_START   = 3'd2;
    localparam dtype_t DTYPE_PIXEL       = 3'd3;
    localparam dtype_t DTYPE_ROW_END     = 3'd4;
    localparam dtype_t DTYPE_FRAME_END   = 3'd5;

    function automatic int unsigned slot_wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/image_kernel_ctrl_if.sv
// Stream-side and row-buffer-side signals of the sequencer. The stream source
// uses the master view; the sequencer itself uses the slave view.
interface image_kernel_ctrl_if
    import image_kernel_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int MAX_COLS    = 1280,
    parameter int ROW_WIDTH   = 12
);
    localparam int ADDR_W = $clog2(MAX_COLS);
    localparam int SLOT_W = $clog2(KERNEL_SIZE);

    logic                 enable;
    logic                 dvi;
    dtype_t               dtypei;
    logic                 dvo;
    dtype_t               dtypeo;
    logic                 we;
    logic [ADDR_W-1:0]    waddr;
    logic [SLOT_W-1:0]    wslot;
    logic [SLOT_W-1:0]    oldest_slot;
    logic [ADDR_W-1:0]    col_idx;
    logic [ROW_WIDTH-1:0] row_idx;
    logic                 win_valid;
    logic                 overflow;
    logic                 proto_err;

    modport master (
        output enable, dvi, dtypei,
        input  dvo, dtypeo, we, waddr, wslot, oldest_slot, col_idx, row_idx,
               win_valid, overflow, proto_err
    );

    modport slave (
        input  enable, dvi, dtypei,
        output dvo, dtypeo, we, waddr, wslot, oldest_slot, col_idx, row_idx,
               win_valid, overflow, proto_err
    );

endinterface

// File: rtl/image_kernel_ctrl_modk_counter.sv
// Modulo-N counter with synchronous clear and advance enable; clear wins.
module image_kernel_ctrl_modk_counter #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == W'(N - 1)) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/image_kernel_ctrl.sv
// Row-buffer sequencer: parses the dtype-tagged pixel stream and owns every
// write pointer, slot and index the kernel row buffers need.
module image_kernel_ctrl
    import image_kernel_ctrl_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int MAX_COLS    = 1280,
    parameter int ROW_WIDTH   = 12
) (
    input  logic                clk,
    input  logic                reset,
    image_kernel_ctrl_if.slave  bus
);

    localparam int ADDR_W = $clog2(MAX_COLS);
    localparam int SLOT_W = $clog2(KERNEL_SIZE);
    localparam int SEEN_W = $clog2(KERNEL_SIZE + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_ROW   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    col_q, col_d;
    logic                 row_full_q, row_full_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [SEEN_W-1:0]    rows_seen_q, rows_seen_d;
    logic                 overflow_q, overflow_d;
    logic                 proto_err_q, proto_err_d;
    logic                 dvo_q, dvo_d;
    dtype_t               dtypeo_q, dtypeo_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [ROW_WIDTH-1:0] row_idx_q, row_idx_d;
    logic                 win_valid_q, win_valid_d;
    logic                 slot_clr, slot_adv;
    logic [SLOT_W-1:0]    wslot;
    logic                 accept;

    assign accept = bus.enable && bus.dvi;

    image_kernel_ctrl_modk_counter #(
        .N (KERNEL_SIZE),
        .W (SLOT_W)
    ) u_wslot (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (slot_clr),
        .en_i    (slot_adv),
        .count_o (wslot)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_full_d  = row_full_q;
        row_d       = row_q;
        rows_seen_d = rows_seen_q;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;
        dvo_d       = 1'b0;
        dtypeo_d    = dtypeo_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        row_idx_d   = row_idx_q;
        win_valid_d = 1'b0;
        slot_clr    = 1'b0;
        slot_adv    = 1'b0;

        if (accept) begin
            dvo_d    = 1'b1;
            dtypeo_d = bus.dtypei;
            case (bus.dtypei)
                DTYPE_FRAME_START: begin
                    // Legal from any state; a partial row is simply abandoned.
                    state_d     = ST_FRAME;
                    col_d       = '0;
                    row_full_d  = 1'b0;
                    row_d       = '0;
                    rows_seen_d = '0;
                    overflow_d  = 1'b0;
                    proto_err_d = 1'b0;
                    slot_clr    = 1'b1;
                end
                DTYPE_ROW_START: begin
                    if (state_q == ST_ROW) begin
                        proto_err_d = 1'b1;
                    end else if (state_q == ST_FRAME) begin
                        state_d    = ST_ROW;
                        col_d      = '0;
                        row_full_d = 1'b0;
                        slot_adv   = (rows_seen_q != '0);
                    end
                end
                DTYPE_PIXEL: begin
                    if (state_q != ST_ROW) begin
                        proto_err_d = 1'b1;
                    end else if (row_full_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        we_d        = 1'b1;
                        waddr_d     = col_q;
                        row_idx_d   = row_q;
                        win_valid_d = (row_q >= ROW_WIDTH'(KERNEL_SIZE - 1)) &&
                                      (col_q >= ADDR_W'(KERNEL_SIZE - 1));
                        // The last column is written once; row_full marks it as used.
                        if (col_q == ADDR_W'(MAX_COLS - 1)) begin
                            row_full_d = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                DTYPE_ROW_END: begin
                    if (state_q != ST_ROW) begin
                        proto_err_d = 1'b1;
                    end else begin
                        state_d = ST_FRAME;
                        if (row_q != '1) begin
                            row_d = row_q + 1'b1;
                        end
                        if (rows_seen_q != SEEN_W'(KERNEL_SIZE)) begin
                            rows_seen_d = rows_seen_q + 1'b1;
                        end
                    end
                end
                DTYPE_FRAME_END: begin
                    if (state_q == ST_ROW) begin
                        proto_err_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_full_q  <= 1'b0;
            row_q       <= '0;
            rows_seen_q <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            dvo_q       <= 1'b0;
            dtypeo_q    <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            row_idx_q   <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_full_q  <= row_full_d;
            row_q       <= row_d;
            rows_seen_q <= rows_seen_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            dvo_q       <= dvo_d;
            dtypeo_q    <= dtypeo_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            row_idx_q   <= row_idx_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign bus.dvo         = dvo_q;
    assign bus.dtypeo      = dtypeo_q;
    assign bus.we          = we_q;
    assign bus.waddr       = waddr_q;
    assign bus.col_idx     = waddr_q;
    assign bus.row_idx     = row_idx_q;
    assign bus.win_valid   = win_valid_q;
    assign bus.overflow    = overflow_q;
    assign bus.proto_err   = proto_err_q;
    assign bus.wslot       = wslot;
    assign bus.oldest_slot = SLOT_W'(slot_wrap_inc(32'(wslot), KERNEL_SIZE));

endmodule

// File: tb/tb_image_kernel_ctrl.sv
// Randomised and directed stimulus for image_kernel_ctrl, checked beat by beat
// against a frame/row/column reference model held in plain integers.
module tb_image_kernel_ctrl;
    import image_kernel_ctrl_pkg::*;

    localparam int K    = 3;
    localparam int MAXC = 8;
    localparam int RW   = 4;
    localparam int RMAX = (1 << RW) - 1;

    logic clk = 1'b0;
    logic reset;

    image_kernel_ctrl_if #(.KERNEL_SIZE(K), .MAX_COLS(MAXC), .ROW_WIDTH(RW)) bus ();

    image_kernel_ctrl #(.KERNEL_SIZE(K), .MAX_COLS(MAXC), .ROW_WIDTH(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 = between frames, 1 = in frame, 2 = inside a row.
    int m_phase, m_col, m_row, m_seen, m_slot;
    bit m_used_last, m_ovf, m_perr;
    int e_dtypeo, e_waddr, e_row_idx;
    bit e_dvo, e_we, e_win;
    int win_cnt, we_cnt;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_col = 0; m_row = 0; m_seen = 0; m_slot = 0;
        m_used_last = 0; m_ovf = 0; m_perr = 0;
        e_dvo = 0; e_dtypeo = 0; e_we = 0; e_waddr = 0; e_row_idx = 0; e_win = 0;
    endtask

    task automatic model_beat(input int dt);
        e_dvo = 1; e_dtypeo = dt; e_we = 0; e_win = 0;
        case (dt)
            1: begin
                m_phase = 1; m_col = 0; m_row = 0; m_seen = 0; m_slot = 0;
                m_used_last = 0; m_ovf = 0; m_perr = 0;
            end
            2: begin
                if (m_phase == 2) m_perr = 1;
                else if (m_phase == 1) begin
                    m_phase = 2; m_col = 0; m_used_last = 0;
                    if (m_seen > 0) m_slot = (m_slot + 1) % K;
                end
            end
            3: begin
                if (m_phase != 2) m_perr = 1;
                else if (m_used_last) m_ovf = 1;
                else begin
                    e_we = 1; e_waddr = m_col; e_row_idx = m_row;
                    e_win = (m_row >= K - 1) && (m_col >= K - 1);
                    if (m_col == MAXC - 1) m_used_last = 1;
                    else m_col++;
                end
            end
            4: begin
                if (m_phase != 2) m_perr = 1;
                else begin
                    m_phase = 1;
                    m_row  = (m_row + 1 > RMAX) ? RMAX : m_row + 1;
                    m_seen = (m_seen + 1 > K) ? K : m_seen + 1;
                end
            end
            5: begin
                if (m_phase == 2) m_perr = 1;
                else if (m_phase == 1) m_phase = 0;
            end
            default: ;
        endcase
    endtask

    // One clock: drive, advance the model, then check every output after the edge.
    task automatic cycle(input bit rst, input bit en, input bit dv, input int dt);
        reset      = rst;
        bus.enable = en;
        bus.dvi    = dv;
        bus.dtypei = dtype_t'(dt);
        if (rst) model_reset();
        else if (en && dv) model_beat(dt);
        else begin
            e_dvo = 0; e_we = 0; e_win = 0;
        end
        @(posedge clk);
        #1;
        if (bus.win_valid) win_cnt++;
        if (bus.we) we_cnt++;
        $display("[%0t] rst=%0b en=%0b dvi=%0b dt=%0d -> dvo=%0b dto=%0d we=%0b waddr=%0d row=%0d slot=%0d win=%0b ovf=%0b perr=%0b",
                 $time, rst, en, dv, dt, bus.dvo, bus.dtypeo, bus.we, bus.waddr, bus.row_idx,
                 bus.wslot, bus.win_valid, bus.overflow, bus.proto_err);
        check_val("dvo", bus.dvo, e_dvo);
        check_val("dtypeo", bus.dtypeo, e_dtypeo);
        check_val("we", bus.we, e_we);
        check_val("waddr", bus.waddr, e_waddr);
        check_val("col_idx", bus.col_idx, e_waddr);
        check_val("row_idx", bus.row_idx, e_row_idx);
        check_val("wslot", bus.wslot, m_slot);
        check_val("oldest_slot", bus.oldest_slot, (m_slot + 1) % K);
        check_val("win_valid", bus.win_valid, e_win);
        check_val("overflow", bus.overflow, m_ovf);
        check_val("proto_err", bus.proto_err, m_perr);
    endtask

    task automatic beat(input int dt);
        cycle(0, 1, 1, dt);
    endtask

    task automatic row_of(input int npix);
        beat(2);
        for (int p = 0; p < npix; p++) beat(3);
        beat(4);
    endtask

    initial begin
        reset = 1; bus.enable = 0; bus.dvi = 0; bus.dtypei = '0;
        model_reset();
        cycle(1, 1, 1, 3);
        cycle(1, 0, 0, 0);
        check_val("reset_dvo", bus.dvo, 0);
        check_val("reset_wslot", bus.wslot, 0);

        // Four 5-pixel rows: window appears on rows 2-3, columns 2-4.
        win_cnt = 0;
        beat(1);
        for (int r = 0; r < 4; r++) row_of(5);
        beat(5);
        check_val("s1_win_beats", win_cnt, 6);
        check_val("s1_perr", bus.proto_err, 0);

        // Overlong row: 8 writes, then overflow, cleared by the next frame start.
        we_cnt = 0;
        beat(1);
        row_of(10);
        check_val("s2_we_beats", we_cnt, 8);
        check_val("s2_ovf", bus.overflow, 1);
        beat(1);
        check_val("s2_ovf_clr", bus.overflow, 0);

        // Pixel outside a row and row end in frame both flag a protocol error.
        beat(3);
        beat(4);
        check_val("s3_perr", bus.proto_err, 1);

        // Enable low mid-row holds everything.
        beat(1);
        beat(2);
        beat(3); beat(3);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 3);
        beat(3);
        check_val("s4_resume_col", bus.waddr, 2);
        beat(4);

        // Reset mid-row with wslot=2, col=3.
        beat(1);
        row_of(1); row_of(1);
        beat(2); beat(3); beat(3); beat(3);
        check_val("s5_pre_slot", bus.wslot, 2);
        cycle(1, 1, 0, 0);
        beat(3);
        check_val("s5_perr", bus.proto_err, 1);

        // Frame start mid-row aborts the row without an error.
        beat(1);
        row_of(2); row_of(2);
        beat(2); beat(3);
        beat(1);
        beat(2); beat(3);
        check_val("s6_waddr", bus.waddr, 0);
        check_val("s6_slot", bus.wslot, 0);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            int sel, dt;
            bit rst, en, dv;
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 99) < 85);
            dv  = ($urandom_range(0, 99) < 80);
            sel = $urandom_range(0, 99);
            if (sel < 50) dt = 3;
            else if (sel < 62) dt = 2;
            else if (sel < 76) dt = 4;
            else if (sel < 82) dt = 1;
            else if (sel < 90) dt = 5;
            else dt = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(6, 7);
            if (dt == 2 && m_phase == 0) dt = 1;
            cycle(rst, en, dv, dt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
